// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad-facing controller for the six-digit lock datapath.
// Assembles BCD key strokes into digit pairs, drives the password/entry
// register write strobes and the compare strobe, and acts on the result.
// Adds timed unlock, consecutive-failure counting and an atomic
// password-change sequence.
//
// Build option macro: LOCKOUT_EN
//   defined   -> reaching MAX_FAIL enters a timed LOCKOUT state (alarm high).
//   undefined -> no LOCKOUT state; alarm stays high while fail_cnt sits at
//                MAX_FAIL, until the next successful compare.
`timescale 1ns/1ps

module lock_sequencer #(
    parameter int OPEN_CYCLES = 16,
    parameter int LOCK_CYCLES = 64,
    parameter int MAX_FAIL    = 3
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       key_vld,
    input  logic [3:0] key_digit,
    input  logic       enter,
    input  logic       set_req,
    input  logic       cancel,
    input  logic       res,
    output logic       m,
    output logic [3:0] pw_a,
    output logic [3:0] pw_b,
    output logic [2:0] pw_we,
    output logic       pw_clr,
    output logic       judge,
    output logic       unlock,
    output logic       alarm,
    output logic [2:0] state,
    output logic [1:0] fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4,
        S_SET     = 3'd5,
        S_COMMIT  = 3'd6
    } state_e;

    // Single winning input per cycle after priority resolution.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_CANCEL,
        EV_ENTER,
        EV_SET,
        EV_KEY
    } event_e;

    // One shared down-counter serves OPEN, LOCKOUT, CHECK and COMMIT.
    localparam int TMAX_OL = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TMAX    = (TMAX_OL > 3) ? TMAX_OL : 3;
    localparam int TW      = $clog2(TMAX);

    localparam logic [TW-1:0] T_ONE       = TW'(1);
    localparam logic [TW-1:0] OPEN_LOAD   = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] CHECK_LOAD  = TW'(1);
    localparam logic [TW-1:0] COMMIT_LOAD = TW'(2);
`ifdef LOCKOUT_EN
    localparam logic [TW-1:0] LOCK_LOAD   = TW'(LOCK_CYCLES - 1);
`endif
    localparam logic [1:0]    FAIL_MAX    = 2'(MAX_FAIL);

    event_e        ev;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    dcnt_q, dcnt_d;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    set_buf_q [6];
    logic [3:0]    set_buf_d [6];
    logic [1:0]    fail_q, fail_d;
    logic [1:0]    fail_inc;
    logic          fail_take;

    logic          m_q, m_d;
    logic [3:0]    pw_a_q, pw_a_d;
    logic [3:0]    pw_b_q, pw_b_d;
    logic [2:0]    pw_we_q, pw_we_d;
    logic          pw_clr_q, pw_clr_d;
    logic          judge_q, judge_d;
    logic          unlock_q, unlock_d;
    logic          alarm_q, alarm_d;

    // Resolve simultaneous inputs: cancel > enter > set_req > valid key.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        ev = EV_NONE;
        if (cancel)                          ev = EV_CANCEL;
        else if (enter)                      ev = EV_ENTER;
        else if (set_req)                    ev = EV_SET;
        else if (key_vld && key_digit <= 4'd9) ev = EV_KEY;
    end

    // Next-state logic: state transitions, timers, digit counter and buffers.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        dcnt_d    = dcnt_q;
        pending_d = pending_q;
        set_buf_d = set_buf_q;
        fail_d    = fail_q;
        fail_inc  = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 2'd1;
        fail_take = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ev == EV_KEY) begin
                    state_d   = S_ENTRY;
                    dcnt_d    = 3'd1;
                    pending_d = key_digit;
                end else if (ev == EV_ENTER) begin
                    fail_take = 1'b1;
                end
            end
            S_ENTRY: begin
                case (ev)
                    EV_CANCEL: state_d = S_IDLE;
                    EV_ENTER: begin
                        if (dcnt_q == 3'd6) begin
                            state_d = S_CHECK;
                            timer_d = CHECK_LOAD;
                        end else begin
                            fail_take = 1'b1;
                        end
                    end
                    EV_KEY: begin
                        if (dcnt_q < 3'd6) begin
                            dcnt_d = dcnt_q + 3'd1;
                            // An even count before the key means it lands on an odd position.
                            if (!dcnt_q[0]) pending_d = key_digit;
                        end
                    end
                    default: ;
                endcase
            end
            S_CHECK: begin
                if (timer_q == '0) begin
                    if (res) begin
                        state_d = S_OPEN;
                        timer_d = OPEN_LOAD;
                        fail_d  = 2'd0;
                    end else begin
                        fail_take = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_OPEN: begin
                if (ev == EV_CANCEL) begin
                    state_d = S_IDLE;
                end else if (ev == EV_SET) begin
                    state_d = S_SET;
                    dcnt_d  = 3'd0;
                end else if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
            S_SET: begin
                case (ev)
                    EV_CANCEL: state_d = S_IDLE;
                    EV_ENTER: begin
                        if (dcnt_q == 3'd6) begin
                            state_d = S_COMMIT;
                            timer_d = COMMIT_LOAD;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    EV_KEY: begin
                        if (dcnt_q < 3'd6) begin
                            set_buf_d[dcnt_q] = key_digit;
                            dcnt_d            = dcnt_q + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
            S_COMMIT: begin
                if (timer_q == '0) state_d = S_IDLE;
                else               timer_d = timer_q - T_ONE;
            end
`ifdef LOCKOUT_EN
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                    fail_d  = 2'd0;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Failure path shared by IDLE enter, short entry and a failed compare.
        if (fail_take) begin
            fail_d  = fail_inc;
            state_d = S_IDLE;
`ifdef LOCKOUT_EN
            if (fail_inc == FAIL_MAX) begin
                state_d = S_LOCKOUT;
                timer_d = LOCK_LOAD;
            end
`endif
        end

        // Any path back to IDLE starts the next entry from scratch.
        if (state_d == S_IDLE) begin
            dcnt_d    = 3'd0;
            pending_d = 4'd0;
        end
    end

    // Output logic: next values of the registered datapath/indicator outputs.
    always_comb begin
        m_d      = !(state_d == S_SET || state_d == S_COMMIT);
        pw_a_d   = pw_a_q;
        pw_b_d   = pw_b_q;
        pw_we_d  = 3'b000;
        pw_clr_d = (state_d == S_IDLE) && (state_q != S_IDLE);
        judge_d  = (state_d == S_CHECK) && (timer_d == CHECK_LOAD);
        unlock_d = (state_d == S_OPEN);
`ifdef LOCKOUT_EN
        alarm_d  = (state_d == S_LOCKOUT);
`else
        alarm_d  = (fail_d == FAIL_MAX);
`endif

        // Even-position key completes a pair: write it straight to the entry register.
        if (state_q == S_ENTRY && ev == EV_KEY && dcnt_q < 3'd6 && dcnt_q[0]) begin
            pw_we_d = 3'b001 << dcnt_q[2:1];
            pw_a_d  = pending_q;
            pw_b_d  = key_digit;
        end

        // COMMIT replays the buffered password one pair per cycle.
        if (state_d == S_COMMIT) begin
            case (timer_d)
                COMMIT_LOAD: begin
                    pw_we_d = 3'b001;
                    pw_a_d  = set_buf_q[0];
                    pw_b_d  = set_buf_q[1];
                end
                T_ONE: begin
                    pw_we_d = 3'b010;
                    pw_a_d  = set_buf_q[2];
                    pw_b_d  = set_buf_q[3];
                end
                default: begin
                    pw_we_d = 3'b100;
                    pw_a_d  = set_buf_q[4];
                    pw_b_d  = set_buf_q[5];
                end
            endcase
        end
    end

    // State register plus all registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            dcnt_q    <= 3'd0;
            pending_q <= 4'd0;
            // NOTE: the password buffer is small and must read as zero after
            // reset, so each entry is reset explicitly rather than left as RAM.
            for (int i = 0; i < 6; i++) set_buf_q[i] <= 4'd0;
            fail_q    <= 2'd0;
            m_q       <= 1'b1;
            pw_a_q    <= 4'd0;
            pw_b_q    <= 4'd0;
            pw_we_q   <= 3'b000;
            pw_clr_q  <= 1'b0;
            judge_q   <= 1'b0;
            unlock_q  <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            timer_q   <= timer_d;
            dcnt_q    <= dcnt_d;
            pending_q <= pending_d;
            set_buf_q <= set_buf_d;
            fail_q    <= fail_d;
            m_q       <= m_d;
            pw_a_q    <= pw_a_d;
            pw_b_q    <= pw_b_d;
            pw_we_q   <= pw_we_d;
            pw_clr_q  <= pw_clr_d;
            judge_q   <= judge_d;
            unlock_q  <= unlock_d;
            alarm_q   <= alarm_d;
        end
    end

    assign m        = m_q;
    assign pw_a     = pw_a_q;
    assign pw_b     = pw_b_q;
    assign pw_we    = pw_we_q;
    assign pw_clr   = pw_clr_q;
    assign judge    = judge_q;
    assign unlock   = unlock_q;
    assign alarm    = alarm_q;
    assign state    = state_q;
    assign fail_cnt = fail_q;

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

- Keypad-facing controller for the six-digit electronic lock datapath. It takes single BCD key strokes and assembles them into digit pairs.
- It drives the mode select, pair write strobes and compare strobe of the password register / judge datapath, then acts on the compare result.
- It adds timed unlock, failure counting with lockout, and an atomic password-change sequence.
- It sits between the keypad debouncer and the lock datapath.

## Interface
Parameters:
- OPEN_CYCLES, 16: cycles `unlock` stays high after a successful compare (≥1).
- LOCK_CYCLES, 64: lockout duration in cycles (≥1).
- MAX_FAIL, 3: consecutive failures that trigger lockout (1–3).

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- key_vld  in  1  one-cycle digit strobe.
- key_digit  in  4  BCD digit, valid with key_vld. Values > 9 are ignored.
- enter  in  1  one-cycle enter key pulse.
- set_req  in  1  one-cycle password-change request.
- cancel  in  1  one-cycle cancel pulse.
- res  in  1  datapath compare result, valid the cycle after `judge`.
- m  out  1  datapath mode: 0 = set register, 1 = entry register.
- pw_a, pw_b  out  4  digit pair for the datapath (first digit, second digit).
- pw_we  out  3  one-hot pair write strobe: bit0 = digits 1–2, bit1 = digits 3–4, bit2 = digits 5–6.
- pw_clr  out  1  one-cycle entry-register clear.
- judge  out  1  one-cycle compare strobe.
- unlock  out  1  lock open.
- alarm  out  1  lockout indicator.
- state  out  3  FSM state, for debug.
- fail_cnt  out  2  consecutive failure count.

## Operation
State encoding:
- IDLE = 0, ENTRY = 1, CHECK = 2, OPEN = 3, LOCKOUT = 4, SET = 5, COMMIT = 6.

Input priority when several inputs arrive in the same cycle:
- cancel > enter > set_req > key_vld. Lower-priority inputs in that cycle are dropped.

IDLE:
- m = 1.
- key_vld with a valid digit → ENTRY. That digit is digit 1.
- enter → counts as a failure (see CHECK fail path).

ENTRY:
- Digit counter `dcnt` runs 0–6.
- An odd-position digit (1, 3, 5) is held in a pending register.
- An even-position digit drives pw_a = pending digit, pw_b = new digit, and pw_we[dcnt/2] = 1 for exactly one cycle, in the cycle after the key.
- Digits after the 6th are ignored.
- enter with dcnt = 6 → CHECK.
- enter with dcnt < 6 → failure path directly, with no judge.
- cancel → IDLE; fail_cnt unchanged.

CHECK (2 cycles):
- Cycle 0: judge = 1.
- Cycle 1: res is sampled.
- res = 1 → OPEN, fail_cnt ← 0.
- res = 0 → fail_cnt + 1. If the new count equals MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.

OPEN:
- unlock = 1 for OPEN_CYCLES cycles, then → IDLE.
- set_req → SET (timer abandoned, unlock drops).
- cancel → IDLE immediately.

SET:
- m = 0.
- Six digits are buffered internally; nothing is written to the datapath yet.
- enter with exactly 6 digits → COMMIT.
- enter with fewer than 6 digits, or cancel → IDLE. The stored password is untouched.

COMMIT (3 cycles):
- m = 0, with pw_we = 001, 010, 100 on consecutive cycles and the matching buffered pairs on pw_a/pw_b.
- Then → IDLE.

LOCKOUT:
- alarm = 1 for LOCK_CYCLES cycles.
- All key inputs are ignored, including cancel.
- On expiry → IDLE, fail_cnt ← 0, alarm drops.

Every entry into IDLE:
- pw_clr = 1 for one cycle, with m = 1.
- dcnt and the pending register clear.

## Timing
Reset values (clr_n low, asynchronous):
- state = IDLE, m = 1, fail_cnt = 0.
- All other outputs are 0; internal buffers are 0.
- pw_clr is not asserted out of reset.
- Reset mid-COMMIT leaves the datapath partially written; this is accepted.

Registered outputs:
- All outputs are registered.
- pw_we / judge follow the triggering input by exactly 1 cycle.

Timers:
- Each timer loads N−1 on state entry and exits on the cycle it reads 0, so the state lasts exactly N cycles.

Result sampling:
- res is sampled only in CHECK cycle 1; it is ignored at all other times.

Counter limits:
- fail_cnt saturates at MAX_FAIL.
- dcnt saturates at 6.

## Configuration
- LOCKOUT_EN defined: LOCKOUT state and alarm behave as described above.
- LOCKOUT_EN undefined: the LOCKOUT state is not built.
  - Reaching MAX_FAIL → IDLE with fail_cnt saturated.
  - alarm is held high until the next successful compare, which clears fail_cnt and alarm.

## Test plan
- **Password set.** Reset, then enter the default 000000 to reach OPEN. set_req, keys 1,2,3,4,5,6, enter → COMMIT pw_we 001/010/100 with pairs (1,2),(3,4),(5,6); m = 0 throughout COMMIT.
- **Correct entry.** Keys 1–6, enter → pw_we pulses at keys 2, 4, 6. judge one cycle after enter; res = 1 → unlock high for exactly 16 cycles; fail_cnt = 0.
- **Lockout.** Three wrong entries (res = 0) → fail_cnt 1, 2, then LOCKOUT. alarm high exactly 64 cycles; a key during lockout is ignored; fail_cnt = 0 after.
- **Short entry.** Keys 1,2,3 then enter → no judge; fail_cnt increments. Cancel mid-entry → IDLE with pw_clr, no increment.
- **Simultaneous inputs.** cancel + enter in the same cycle in ENTRY → IDLE, no judge. key_digit = 4'hC with key_vld → ignored, dcnt unchanged.
- **Reset during OPEN, and build without LOCKOUT_EN.** clr_n low during OPEN → unlock = 0 immediately, state = 0. Without LOCKOUT_EN, three failures → alarm stays high until a correct entry.
